regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
- Parametrised successor to the 32x32 GPR file for the pipelined CPU.
- Provides NUM_RD read ports with same-cycle write-through bypass and one write port.
- Adds a per-register pending-write scoreboard: a saturating counter per register tracks in-flight producers.
- Decode uses `rd_busy` to stall on RAW hazards; writeback retires producers.

Parameters:
- DATA_W, 32, register width.
- ADDR_W, 5, address width; depth is NREG = 2**ADDR_W.
- NUM_RD, 2, number of read ports (1..4).
- CNT_W, 2, pending-counter width per register; maximum count is 2**CNT_W-1.
- TRACE, 1, when 1 the simulation-only writeback trace line is enabled.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  read data per port, combinational.
- rd_busy  out  NUM_RD  per port, 1 when the register has an unretired producer.
- we  in  1  writeback enable.
- wa  in  ADDR_W  writeback address.
- wd  in  DATA_W  writeback data.
- wpc  in  32  PC of the writing instruction (trace only).
- wb_retire  in  1  the writeback retires one scoreboard claim (qualified by we).
- claim_en  in  1  decode issues a producer for claim_addr.
- claim_addr  in  ADDR_W  destination register being claimed.
- claim_full  out  1  combinational; claim_en=1 and the target counter is at maximum.
- flush  in  1  clears all pending counters (pipeline flush).
- busy_vec  out  NREG  registered; bit r = (cnt[r] != 0).

Behaviour:
- Reset (synchronous, active-high): all registers become 0 and all counters become 0.
  - After the edge: every rd_data = 0, rd_busy = 0, busy_vec = 0.
  - claim_full is combinational and therefore 0 whenever claim_en=0.
- Register 0:
  - Always reads 0.
  - Writes to it are dropped and produce no trace line.
  - Claims to it are ignored and never raise claim_full.
  - rd_busy for it is always 0.
- Data write:
  - On the edge with we=1 and wa!=0, reg[wa] <= wd.
  - If TRACE, print "time@wpc: $wa <= wd" in the existing GRF format.
- Read (port k, combinational):
  - If rd_addr_k == 0: output 0.
  - Else if we=1 and wa == rd_addr_k: output wd (bypass).
  - Otherwise output reg[rd_addr_k].
  - All ports are independent; identical addresses on several ports are legal.
- Counter update per register r, evaluated on each edge:
  - inc = claim_en & (claim_addr==r) & (r!=0) & (cnt[r] != max).
  - dec = we & wb_retire & (wa==r) & (r!=0) & (cnt[r] != 0).
  - inc & dec: cnt unchanged.
  - inc only: cnt+1. dec only: cnt-1.
  - A claim at saturation is dropped; decode must hold it while claim_full=1.
  - A retire with cnt==0 performs the data write, leaves cnt at 0 and raises no error.
- rd_busy_k = (cnt[a] != 0) && !(cnt[a]==1 && we && wb_retire && wa==a), where a = rd_addr_k.
  - The last producer retiring in the same cycle is bypassed, so the port is not busy.
  - A same-cycle claim to a does not affect rd_busy this cycle; the new count is visible next cycle.
- Flush:
  - On the edge, all cnt <= 0.
  - Claims and retires in that cycle are discarded for the counters.
  - A data write in the same cycle still commits.
- Priority: Reset > flush > claim/retire.
- Latency: reads and busy are 0-cycle; data and counters take effect at the next edge.
- The register array has no reset other than Reset.

Decomposition:
- Shared package cpu_pkg holds:
  - DATA_W and ADDR_W defaults.
  - The REG_ZERO constant.
  - The trace-format string.
- One sub-module, sb_counter: a single saturating up/down counter.
  - Ports: inc, dec, clr, cnt, full, nz.
  - Instantiated NREG-1 times by generate.
- Read muxes and bypass stay inline.

Test Plan:
- Reset, then read $5 on both ports -> rd_data=0, rd_busy=0; busy_vec=0.
- Write 0xDEADBEEF to $3 while port0 reads $3 in the same cycle -> port0=0xDEADBEEF (bypass); after the edge, port1 reading $3 -> 0xDEADBEEF. Write 0x1234 to $0 -> reads 0 and no trace line.
- Counter lifecycle on $7:
  - Claim $7 three times -> cnt=3, busy_vec[7]=1.
  - A fourth claim -> claim_full=1 and cnt stays 3.
  - Retire once with we=1 -> cnt=2, rd_busy=1.
  - Retire twice -> cnt 0; in the cycle cnt==1 is retired, reading $7 gives rd_busy=0 and the bypassed data.
- Simultaneous claim and retire of $9 with cnt=1 -> cnt stays 1, rd_busy=1 next cycle; claim and retire to different registers both take effect.
- Claim $4 and $6, then assert flush together with we=1, wa=$4, wd=0x55 -> busy_vec=0 next cycle and reg[4]=0x55.
- Reset asserted mid-operation with cnt[$7]=2 and pending claim_en -> after the edge all counters are 0, all registers 0 and the claim is dropped.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU constants: default GPR geometry, the hard-wired zero register
// and the writeback trace format.
package cpu_pkg;
  localparam int    DATA_W_DEF = 32;
  localparam int    ADDR_W_DEF = 5;
  localparam int    REG_ZERO   = 0;
  // time@pc: $reg <= data
  localparam string TRACE_FMT  = "%0t@%h: $%0d <= %h";
endpackage

// File: rtl/sb_counter.sv
// Saturating up/down pending-producer counter for one register.
module sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             full,
  output logic             nz
);
  logic up, dn;

  assign full = &cnt;
  assign nz   = |cnt;
  // saturation and underflow requests are simply dropped
  assign up   = inc & ~full;
  assign dn   = dec & nz;

  always_ff @(posedge Clk) begin
    if (Reset || clr)    cnt <= '0;
    else if (up && !dn)  cnt <= cnt + CNT_W'(1);
    else if (dn && !up)  cnt <= cnt - CNT_W'(1);
  end
endmodule

// File: rtl/regfile_sb.sv
// Multi-port GPR file with write-through bypass and a per-register
// pending-write scoreboard used by decode for RAW stalls.
module regfile_sb
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = 2,
  parameter int CNT_W  = 2,
  parameter int TRACE  = 1,
  localparam int NREG  = 2**ADDR_W
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wa,
  input  logic [DATA_W-1:0]        wd,
  input  logic [31:0]              wpc,
  input  logic                     wb_retire,
  input  logic                     claim_en,
  input  logic [ADDR_W-1:0]        claim_addr,
  output logic                     claim_full,
  input  logic                     flush,
  output logic [NREG-1:0]          busy_vec
);
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(REG_ZERO);

  logic [NREG-1:0][DATA_W-1:0] regs;
  logic [NREG-1:0][CNT_W-1:0]  cnt;
  logic [NREG-1:0]             full, nz;
  logic [NUM_RD-1:0][ADDR_W-1:0] ra;
  logic [NUM_RD-1:0][DATA_W-1:0] rdv;
  logic                        wr_ok, ret_ok;

  assign wr_ok  = we && (wa != ZERO_A);
  assign ret_ok = wr_ok && wb_retire;

  // register 0 is never written, so it stays at its reset value of 0
  always_ff @(posedge Clk) begin
    if (Reset)      regs     <= '0;
    else if (wr_ok) regs[wa] <= wd;
  end

  assign cnt[0]  = '0;
  assign full[0] = 1'b0;
  assign nz[0]   = 1'b0;

  for (genvar r = 1; r < NREG; r++) begin : g_cnt
    sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .Clk   (Clk),
      .Reset (Reset),
      .inc   (claim_en && (claim_addr == ADDR_W'(r))),
      .dec   (ret_ok && (wa == ADDR_W'(r))),
      .clr   (flush),
      .cnt   (cnt[r]),
      .full  (full[r]),
      .nz    (nz[r])
    );
  end

  assign busy_vec   = nz;
  assign claim_full = claim_en && (claim_addr != ZERO_A) && full[claim_addr];

  assign ra      = rd_addr;
  assign rd_data = rdv;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    always_comb begin
      rdv[k] = regs[ra[k]];
      if (ra[k] == ZERO_A)            rdv[k] = '0;
      else if (we && (wa == ra[k]))   rdv[k] = wd;
    end
    // a last producer retiring this cycle is covered by the bypass
    assign rd_busy[k] = nz[ra[k]] &&
                        !((cnt[ra[k]] == CNT_W'(1)) && ret_ok && (wa == ra[k]));
  end

`ifndef SYNTHESIS
  if (TRACE != 0) begin : g_trace
    always @(posedge Clk) begin
      if (!Reset && wr_ok)
        $display("%s", $sformatf(TRACE_FMT, $time, wpc, wa, wd));
    end
  end
`endif
endmodule

// File: tb/tb_regfile_sb.sv
// Directed + random bench for regfile_sb against an array/counter reference model.
module tb_regfile_sb;
  localparam int DW = 32, AW = 5, NR = 2, NREG = 32, CMAX = 3;

  logic            Clk = 1'b0;
  logic            Reset;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]   rd_busy;
  logic            we, wb_retire, claim_en, flush;
  logic [AW-1:0]   wa, claim_addr;
  logic [DW-1:0]   wd;
  logic [31:0]     wpc;
  logic            claim_full;
  logic [NREG-1:0] busy_vec;

  int vectors = 0;
  int fails   = 0;

  logic [DW-1:0] mreg [NREG];
  int            mcnt [NREG];

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .CNT_W(2), .TRACE(1)) dut (
    .Clk(Clk), .Reset(Reset), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .we(we), .wa(wa), .wd(wd), .wpc(wpc), .wb_retire(wb_retire),
    .claim_en(claim_en), .claim_addr(claim_addr), .claim_full(claim_full),
    .flush(flush), .busy_vec(busy_vec)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_rd(input int a);
    if (a == 0) return '0;
    if (we && int'(wa) == a) return wd;
    return mreg[a];
  endfunction

  function automatic logic exp_busy(input int a);
    return (mcnt[a] != 0) &&
           !(mcnt[a] == 1 && we && wb_retire && int'(wa) == a && a != 0);
  endfunction

  function automatic logic [NREG-1:0] exp_bv();
    logic [NREG-1:0] v;
    for (int r = 0; r < NREG; r++) v[r] = (mcnt[r] != 0);
    return v;
  endfunction

  task automatic model_edge();
    if (Reset) begin
      for (int r = 0; r < NREG; r++) begin mreg[r] = '0; mcnt[r] = 0; end
    end else begin
      int  c, w;
      bit  ci, ri;
      c = int'(claim_addr);
      w = int'(wa);
      if (we && w != 0) mreg[w] = wd;
      if (flush) begin
        for (int r = 0; r < NREG; r++) mcnt[r] = 0;
      end else begin
        ci = claim_en && c != 0 && mcnt[c] < CMAX;
        ri = we && wb_retire && w != 0 && mcnt[w] > 0;
        if (ci) mcnt[c]++;
        if (ri) mcnt[w]--;
      end
    end
  endtask

  // check every output against the model, then clock once
  task automatic cyc();
    #2;
    for (int k = 0; k < NR; k++) begin
      int a;
      a = int'(rd_addr[k*AW +: AW]);
      chk($sformatf("rd_data%0d", k), rd_data[k*DW +: DW], exp_rd(a));
      chk($sformatf("rd_busy%0d", k), 32'(rd_busy[k]), 32'(exp_busy(a)));
    end
    chk("claim_full", 32'(claim_full),
        32'(claim_en && claim_addr != 0 && mcnt[claim_addr] == CMAX));
    chk("busy_vec", busy_vec, exp_bv());
    @(posedge Clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    Reset = 0; we = 0; wa = '0; wd = '0; wpc = '0; wb_retire = 0;
    claim_en = 0; claim_addr = '0; flush = 0;
  endtask

  task automatic rd(input int a0, input int a1);
    rd_addr = {AW'(a1), AW'(a0)};
  endtask

  initial begin
    idle();
    rd(5, 5);
    Reset = 1;
    @(posedge Clk);
    model_edge();
    #1;
    idle();
    #1;
    chk("reset_rd0", rd_data[31:0], 32'h0);
    chk("reset_busy", 32'(rd_busy), 32'h0);
    chk("reset_bv", busy_vec, 32'h0);
    cyc();

    // write with same-cycle bypass on port0
    we = 1; wa = 3; wd = 32'hDEADBEEF; wpc = 32'h0000_3000; rd(3, 0);
    #1 chk("bypass_p0", rd_data[31:0], 32'hDEADBEEF);
    cyc();
    idle(); rd(0, 3);
    #1 chk("stored_p1", rd_data[63:32], 32'hDEADBEEF);
    cyc();
    we = 1; wa = 0; wd = 32'h1234; rd(0, 0);
    cyc();
    idle();
    #1 chk("r0_zero", rd_data[31:0], 32'h0);
    cyc();

    // counter lifecycle on $7
    rd(7, 7);
    claim_en = 1; claim_addr = 7;
    repeat (3) cyc();
    #1 chk("bv7_sat", 32'(busy_vec[7]), 32'h1);
    chk("full_4th", 32'(claim_full), 32'h1);
    cyc();
    claim_en = 0;
    we = 1; wb_retire = 1; wa = 7; wd = 32'hA1;
    cyc();
    we = 0; wb_retire = 0;
    #1 chk("busy7_cnt2", 32'(rd_busy[0]), 32'h1);
    cyc();
    we = 1; wb_retire = 1; wa = 7; wd = 32'hA2;
    cyc();
    wd = 32'hA3;
    #1 chk("last_ret_busy", 32'(rd_busy[0]), 32'h0);
    chk("last_ret_data", rd_data[31:0], 32'hA3);
    cyc();
    idle();
    #1 chk("bv7_clear", 32'(busy_vec[7]), 32'h0);
    cyc();

    // simultaneous claim and retire
    rd(9, 10);
    claim_en = 1; claim_addr = 9;
    cyc();
    we = 1; wb_retire = 1; wa = 9; wd = 32'h99;
    cyc();
    idle(); rd(9, 10);
    #1 chk("busy9_hold", 32'(rd_busy[0]), 32'h1);
    claim_en = 1; claim_addr = 10;
    we = 1; wb_retire = 1; wa = 9; wd = 32'h98;
    cyc();
    idle();
    #1 chk("bv9_10", 32'(busy_vec[10:9]), 32'h2);
    cyc();

    // flush with a concurrent data write
    claim_en = 1; claim_addr = 4; cyc();
    claim_addr = 6; cyc();
    idle();
    flush = 1; we = 1; wa = 4; wd = 32'h55; claim_en = 1; claim_addr = 6;
    cyc();
    idle(); rd(4, 6);
    #1 chk("flush_bv", busy_vec, 32'h0);
    chk("flush_wr", rd_data[31:0], 32'h55);
    cyc();

    // reset mid-operation
    claim_en = 1; claim_addr = 7;
    repeat (2) cyc();
    Reset = 1;
    cyc();
    idle(); rd(3, 7);
    #1 chk("rst_bv", busy_vec, 32'h0);
    chk("rst_reg3", rd_data[31:0], 32'h0);
    cyc();

    // random traffic on a narrow address window to hit saturation/bypass
    for (int i = 0; i < 400; i++) begin
      Reset      = ($urandom_range(0, 199) == 0);
      flush      = ($urandom_range(0, 29) == 0);
      we         = $urandom_range(0, 1);
      wa         = AW'($urandom_range(0, 7));
      wd         = $urandom;
      wpc        = 32'(i * 4);
      wb_retire  = $urandom_range(0, 1);
      claim_en   = ($urandom_range(0, 2) != 0);
      claim_addr = AW'($urandom_range(0, 7));
      rd($urandom_range(0, 8), $urandom_range(0, 8));
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
